// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control stage: state encoding and
// BCD digit limits for the preset clamp.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } sw_state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/pb_debounce_onepulse.sv
// Pushbutton conditioner: 2-flop synchroniser, sampled shift-register
// debounce and a one-cycle pulse on the rising edge of the debounced level.
module pb_debounce_onepulse #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic pb,
  output logic pulse
);

  logic [1:0]        sync_q;
  logic [DB_LEN-1:0] shift_q;
  logic              level_q;
  logic              level_d_q;
  logic              pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      shift_q   <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pb};
      if (sample)
        shift_q <= (shift_q << 1) | DB_LEN'(sync_q[1]);
      // Mixed history keeps the previous level (hysteresis against bounce).
      if (&shift_q)
        level_q <= 1'b1;
      else if (~|shift_q)
        level_q <= 1'b0;
      level_d_q <= level_q;
      pulse_q   <= level_q & ~level_d_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: conditions start/reset buttons, sequences
// IDLE/RUN/PAUSE, divides clk to a count tick and latches the preset digits.
//
// state | meaning
// IDLE  | stopped, divider cleared, preset latch tracks the switches
// RUN   | divider counting, en ticks once per DIV_CNT cycles
// PAUSE | divider and preset held, no ticks
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIV_CNT = 100_000_000,
  parameter int DB_DIV  = 1_000_000,
  parameter int DB_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_start,
  input  logic       pb_rst,
  input  logic       sw_mode,
  input  logic [3:0] sw_init_1,
  input  logic [3:0] sw_init_0,
  output logic       en,
  output logic       pb_rst_debounced,
  output logic       mode_enable,
  output logic [3:0] initial_1,
  output logic [3:0] initial_0,
  output logic       running
);

  localparam int DBW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam int DVW = $clog2(DIV_CNT);

  logic [DBW-1:0] db_cnt_q;
  logic           sample_q;
  logic           start_p;
  logic           rst_p;
  sw_state_e      state_q, state_nxt;
  logic [DVW-1:0] div_q;
  logic           en_q;
  logic           running_q;
  logic [1:0]     boot_q;
  logic           rst_db_q;
  logic           mode_q;
  logic [3:0]     tens_q, units_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      sample_q <= 1'b0;
    end else if (db_cnt_q == DBW'(DB_DIV - 1)) begin
      db_cnt_q <= '0;
      sample_q <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_q + DBW'(1);
      sample_q <= 1'b0;
    end
  end

  pb_debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (sample_q),
    .pb     (pb_start),
    .pulse  (start_p)
  );

  pb_debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (sample_q),
    .pb     (pb_rst),
    .pulse  (rst_p)
  );

  always_comb begin
    state_nxt = state_q;
    if (rst_p) begin
      state_nxt = IDLE;
    end else if (start_p) begin
      case (state_q)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      div_q     <= '0;
      en_q      <= 1'b0;
      boot_q    <= 2'b00;
      rst_db_q  <= 1'b0;
      mode_q    <= 1'b0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
    end else begin
      state_q   <= state_nxt;
      running_q <= (state_nxt == RUN);
      en_q      <= 1'b0;
      // Divider only advances on edges that stay in RUN, so the edge that
      // pauses neither counts nor ticks and the partial second survives.
      if (state_nxt == IDLE) begin
        div_q <= '0;
      end else if (state_q == RUN && state_nxt == RUN) begin
        if (div_q == DVW'(DIV_CNT - 1)) begin
          div_q <= '0;
          en_q  <= 1'b1;
        end else begin
          div_q <= div_q + DVW'(1);
        end
      end
      // Power-up reload fires once the preset latch has had a cycle to settle.
      boot_q   <= {boot_q[0], 1'b1};
      rst_db_q <= rst_p | (boot_q[0] & ~boot_q[1]);
      if (state_q == IDLE) begin
        mode_q  <= sw_mode;
        tens_q  <= clamp_digit(sw_init_1, TENS_MAX);
        units_q <= clamp_digit(sw_init_0, UNITS_MAX);
      end
    end
  end

  assign en               = en_q;
  assign running          = running_q;
  assign pb_rst_debounced = rst_db_q;
  assign mode_enable      = mode_q;
  assign initial_1        = mode_q ? tens_q  : 4'd0;
  assign initial_0        = mode_q ? units_q : 4'd0;

endmodule
